// File: rtl/seven_seg_scan_ctrl.sv
// Scans DiceGame results onto an 8-digit common-anode display; snapshot per frame, no tearing.
// Latency: captured value shows GUARD cycles into its slot; no backpressure (free-running scan).
module seven_seg_scan_ctrl #(
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD       = 4,
    parameter int BLINK_DIV   = 125
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       Win,
    input  logic       Lose,
    input  logic       Roll,
    input  logic [2:0] DiceOut1,
    input  logic [2:0] DiceOut2,
    output logic [7:0] Anode,
    output logic [6:0] Cathode,
    output logic       frame_tick
);
    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_P     = 7'b0001100;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_S     = 7'b0010010;
    localparam logic [6:0] SEG_L     = 7'b1000111;
    localparam logic [6:0] SEG_O     = 7'b1000000;
    localparam logic [6:0] SEG_E     = 7'b0000110;

    function automatic logic [6:0] num_seg(input logic [3:0] n);
        case (n)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return SEG_BLANK;
        endcase
    endfunction

    function automatic logic [6:0] die_seg(input logic [2:0] v);
        if (v == 3'd0)      return SEG_BLANK;
        else if (v == 3'd7) return SEG_DASH;
        else                return num_seg({1'b0, v});
    endfunction

    logic [PW-1:0] presc_q, presc_d;
    logic [2:0]    idx_q, idx_d;
    logic          first_q, first_d;
    logic          snap_win_q, snap_win_d, snap_lose_q, snap_lose_d, snap_roll_q, snap_roll_d;
    logic [2:0]    snap_d1_q, snap_d1_d, snap_d2_q, snap_d2_d;
    logic [FW-1:0] frame_cnt_q, frame_cnt_d;
    logic          phase_q, phase_d;
    logic [7:0]    anode_q, anode_d;
    logic [6:0]    cathode_q, cathode_d;
    logic          frame_tick_q, frame_tick_d;

    logic          presc_wrap, capture, dice_blank;
    logic [3:0]    sum_w, ones_w;

    always_comb begin
        presc_wrap = (presc_q == PW'(REFRESH_DIV - 1));
        presc_d    = presc_wrap ? '0 : presc_q + 1'b1;
        idx_d      = presc_wrap ? idx_q + 3'd1 : idx_q;
        // First cycle out of reset also captures, so the display never starts stale.
        capture    = first_q | (presc_wrap & (idx_q == 3'd7));
        first_d    = 1'b0;

        snap_win_d   = capture ? Win      : snap_win_q;
        snap_lose_d  = capture ? Lose     : snap_lose_q;
        snap_roll_d  = capture ? Roll     : snap_roll_q;
        snap_d1_d    = capture ? DiceOut1 : snap_d1_q;
        snap_d2_d    = capture ? DiceOut2 : snap_d2_q;
        frame_tick_d = capture;

        frame_cnt_d = frame_cnt_q;
        phase_d     = phase_q;
        if (!(snap_win_q | snap_lose_q)) begin
            frame_cnt_d = '0;
            phase_d     = 1'b1;
        end else if (frame_tick_q) begin
            if (frame_cnt_q == FW'(BLINK_DIV - 1)) begin
                frame_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end

        anode_d = (presc_q < PW'(GUARD)) ? 8'hFF : ~(8'd1 << idx_q);

        sum_w      = {1'b0, snap_d1_q} + {1'b0, snap_d2_q};
        ones_w     = (sum_w >= 4'd10) ? sum_w - 4'd10 : sum_w;
        dice_blank = (snap_d1_q == 3'd0) || (snap_d2_q == 3'd0);

        cathode_d = SEG_BLANK;
        case (idx_q)
            3'd0: cathode_d = die_seg(snap_d1_q);
            3'd1: cathode_d = die_seg(snap_d2_q);
            3'd2: cathode_d = dice_blank ? SEG_BLANK : num_seg(ones_w);
            3'd3: cathode_d = (dice_blank || sum_w < 4'd10) ? SEG_BLANK : num_seg(4'd1);
            default: begin
                if (!phase_q) begin
                    cathode_d = SEG_BLANK;
                end else if (snap_lose_q) begin
                    case (idx_q)
                        3'd7:    cathode_d = SEG_L;
                        3'd6:    cathode_d = SEG_O;
                        3'd5:    cathode_d = SEG_S;
                        default: cathode_d = SEG_E;
                    endcase
                end else if (snap_win_q) begin
                    case (idx_q)
                        3'd7:    cathode_d = SEG_P;
                        3'd6:    cathode_d = SEG_A;
                        default: cathode_d = SEG_S;
                    endcase
                end else if (snap_roll_q) begin
                    cathode_d = SEG_DASH;
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            presc_q      <= '0;
            idx_q        <= '0;
            first_q      <= 1'b1;
            snap_win_q   <= 1'b0;
            snap_lose_q  <= 1'b0;
            snap_roll_q  <= 1'b0;
            snap_d1_q    <= '0;
            snap_d2_q    <= '0;
            frame_cnt_q  <= '0;
            phase_q      <= 1'b1;
            anode_q      <= 8'hFF;
            cathode_q    <= 7'h7F;
            frame_tick_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            first_q      <= first_d;
            snap_win_q   <= snap_win_d;
            snap_lose_q  <= snap_lose_d;
            snap_roll_q  <= snap_roll_d;
            snap_d1_q    <= snap_d1_d;
            snap_d2_q    <= snap_d2_d;
            frame_cnt_q  <= frame_cnt_d;
            phase_q      <= phase_d;
            anode_q      <= anode_d;
            cathode_q    <= cathode_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign Anode      = anode_q;
    assign Cathode    = cathode_q;
    assign frame_tick = frame_tick_q;
endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Randomized bench for seven_seg_scan_ctrl against a frame-level display model.
module tb_seven_seg_scan_ctrl;
    localparam int R  = 4;
    localparam int G  = 1;
    localparam int BD = 2;
    localparam int F  = 8 * R;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       win = 1'b0, lose = 1'b0, roll = 1'b0;
    logic [2:0] d1 = 3'd0, d2 = 3'd0;
    logic [7:0] anode;
    logic [6:0] cathode;
    logic       frame_tick;

    always #5 clk = ~clk;

    seven_seg_scan_ctrl #(.REFRESH_DIV(R), .GUARD(G), .BLINK_DIV(BD)) dut (
        .CLK(clk), .reset(reset), .Win(win), .Lose(lose), .Roll(roll),
        .DiceOut1(d1), .DiceOut2(d2),
        .Anode(anode), .Cathode(cathode), .frame_tick(frame_tick)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Model state: cycle count since reset release, frame snapshot, blink state.
    int  t = 0;
    bit  m_win, m_lose, m_roll;
    int  m_d1, m_d2;
    bit  m_phase = 1'b1;
    int  m_cnt = 0;
    bit  m_tick_pend = 1'b0;
    logic [7:0] exp_anode;
    logic [6:0] exp_cath;
    logic       exp_tick;

    function automatic logic [6:0] seg_of(input byte c);
        case (c)
            "0": return 7'b1000000;
            "1": return 7'b1111001;
            "2": return 7'b0100100;
            "3": return 7'b0110000;
            "4": return 7'b0011001;
            "5": return 7'b0010010;
            "6": return 7'b0000010;
            "7": return 7'b1111000;
            "8": return 7'b0000000;
            "9": return 7'b0010000;
            "P": return 7'b0001100;
            "A": return 7'b0001000;
            "S": return 7'b0010010;
            "L": return 7'b1000111;
            "O": return 7'b1000000;
            "E": return 7'b0000110;
            "-": return 7'b0111111;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic byte die_char(input int v);
        if (v == 0) return " ";
        if (v == 7) return "-";
        return byte'(48 + v);
    endfunction

    function automatic byte char_at(input int d);
        string word;
        int    s;
        s = m_d1 + m_d2;
        case (d)
            0: return die_char(m_d1);
            1: return die_char(m_d2);
            2: return (m_d1 == 0 || m_d2 == 0) ? " " : byte'(48 + s % 10);
            3: return (m_d1 == 0 || m_d2 == 0 || s < 10) ? " " : "1";
            default: begin
                if (m_lose)      word = "LOSE";
                else if (m_win)  word = "PASS";
                else if (m_roll) word = "----";
                else             word = "    ";
                if (!m_phase) return " ";
                return word[7 - d];
            end
        endcase
    endfunction

    task automatic step();
        int  pos, idx;
        bit  cap;
        @(posedge clk);
        if (reset) begin
            exp_anode = 8'hFF; exp_cath = 7'h7F; exp_tick = 1'b0;
            t = 0; m_win = 0; m_lose = 0; m_roll = 0; m_d1 = 0; m_d2 = 0;
            m_phase = 1'b1; m_cnt = 0; m_tick_pend = 1'b0;
        end else begin
            pos = t % F;
            idx = pos / R;
            exp_anode = ((pos % R) < G) ? 8'hFF : ~(8'd1 << idx);
            exp_cath  = seg_of(char_at(idx));
            if (m_tick_pend) begin
                if (m_win || m_lose) begin
                    if (m_cnt == BD - 1) begin m_cnt = 0; m_phase = ~m_phase; end
                    else m_cnt++;
                end else begin
                    m_cnt = 0; m_phase = 1'b1;
                end
            end
            cap = (t == 0) || (pos == F - 1);
            exp_tick = cap;
            if (cap) begin
                m_win = win; m_lose = lose; m_roll = roll; m_d1 = int'(d1); m_d2 = int'(d2);
            end
            m_tick_pend = cap;
            t++;
        end
        @(negedge clk);
        check_val($sformatf("anode t=%0d", t), 32'(anode), 32'(exp_anode));
        check_val($sformatf("cathode t=%0d", t), 32'(cathode), 32'(exp_cath));
        check_val($sformatf("frame_tick t=%0d", t), 32'(frame_tick), 32'(exp_tick));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int guard_cnt;
        reset = 1'b1;
        run(3);
        d1 = 3'd3; d2 = 3'd4; roll = 1'b1;
        reset = 1'b0;
        run(2 * F);

        d1 = 3'd6; d2 = 3'd6; win = 1'b1; roll = 1'b0;
        run(7 * F);

        lose = 1'b1; d1 = 3'd0; d2 = 3'd5;
        run(3 * F);

        // Mid-frame change of die 1 while digit 3 is being scanned.
        win = 1'b0; lose = 1'b0; d1 = 3'd2; d2 = 3'd1;
        run(F);
        guard_cnt = 0;
        while ((t % F) != 3 * R + 2 && guard_cnt < 2 * F) begin step(); guard_cnt++; end
        check_val("reach_idx3", 32'(guard_cnt < 2 * F), 32'd1);
        d1 = 3'd5;
        run(2 * F);

        // Reset while digit 5 is scanned during a blanked blink phase.
        win = 1'b1;
        guard_cnt = 0;
        while (!(m_phase == 1'b0 && m_win && ((t % F) / R) == 5) && guard_cnt < 10 * F) begin
            step(); guard_cnt++;
        end
        check_val("reach_blink0_idx5", 32'(guard_cnt < 10 * F), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        run(3 * F);

        for (int seg = 0; seg < 60; seg++) begin
            d1 = 3'($urandom_range(0, 7));
            d2 = 3'($urandom_range(0, 7));
            win  = ($urandom_range(0, 2) == 0);
            lose = ($urandom_range(0, 3) == 0);
            roll = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 14) == 0) begin
                reset = 1'b1;
                run($urandom_range(1, 3));
                reset = 1'b0;
            end
            run($urandom_range(5, 90));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
